// File: rtl/icache_line_fetcher_pkg.sv
// Shared types and constants for the I-cache line fetcher.
package icache_line_fetcher_pkg;

   localparam int          LINE_BITS        = 256;
   localparam int          LINE_OFFSET_BITS = 5;
   localparam logic [31:0] LINE_BYTES       = 32'd32;
   localparam logic [31:0] LINE_MASK        = ~(LINE_BYTES - 32'd1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_REQ     = 3'd1,
      ST_FILL    = 3'd2,
      ST_RESP    = 3'd3,
      ST_HOLD    = 3'd4,
      ST_PF_REQ  = 3'd5,
      ST_PF_FILL = 3'd6
   } fetch_state_t;

   // Line-align a byte address (offset bits forced to zero).
   function automatic logic [31:0] line_of(input logic [31:0] addr);
      return addr & LINE_MASK;
   endfunction

endpackage

// File: rtl/icache_line_fetcher_beat_asm.sv
// Beat assembler: collects BEATS memory beats into one cache line, slot by slot.
module icache_line_fetcher_beat_asm
   import icache_line_fetcher_pkg::*;
#(
   parameter int BEAT_BITS = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear_i,
   input  logic                 beat_valid_i,
   input  logic [BEAT_BITS-1:0] beat_i,
   output logic [LINE_BITS-1:0] line_o,
   output logic                 done_o
);

   localparam int                  BEATS    = LINE_BITS / BEAT_BITS;
   localparam int                  CNT_BITS = $clog2(BEATS);
   localparam logic [CNT_BITS-1:0] LAST     = CNT_BITS'(BEATS - 1);

   logic [CNT_BITS-1:0]  cnt_q, cnt_d;
   logic [LINE_BITS-1:0] line_q, line_d;

   // Next-state: clear restarts at slot 0, an accepted beat fills the current slot.
   always_comb begin
      cnt_d  = cnt_q;
      line_d = line_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (beat_valid_i) begin
         for (int i = 0; i < BEATS; i++) begin
            if (cnt_q == CNT_BITS'(i)) begin
               line_d[i*BEAT_BITS +: BEAT_BITS] = beat_i;
            end else begin
               line_d[i*BEAT_BITS +: BEAT_BITS] = line_q[i*BEAT_BITS +: BEAT_BITS];
            end
         end
         cnt_d = cnt_q + CNT_BITS'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Beat counter and line storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         line_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         line_q <= line_d;
      end
   end

   // line_o includes the beat accepted this cycle so the final beat can be forwarded directly.
   assign line_o = line_d;
   assign done_o = beat_valid_i && !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/icache_line_fetcher.sv
// I-cache DFP responder: demand line fetch from burst memory plus one-line next-line prefetch.
module icache_line_fetcher
   import icache_line_fetcher_pkg::*;
#(
   parameter int BEAT_BITS   = 64,
   parameter bit PREFETCH_EN = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          dfp_addr,
   input  logic                 dfp_read,
   output logic [LINE_BITS-1:0] dfp_rdata,
   output logic [31:0]          dfp_raddr,
   output logic                 dfp_resp,
   output logic [31:0]          bmem_addr,
   output logic                 bmem_read,
   input  logic                 bmem_ready,
   input  logic [31:0]          bmem_raddr,
   input  logic [BEAT_BITS-1:0] bmem_rdata,
   input  logic                 bmem_rvalid
);

   fetch_state_t         state_q, state_d;
   logic [31:0]          cur_q, cur_d;          // demand line being served or latched
   logic [31:0]          pf_addr_q, pf_addr_d;
   logic                 pf_valid_q, pf_valid_d;
   logic                 pend_q, pend_d;        // demand latched while a prefetch runs
   logic                 dmiss_q, dmiss_d;      // current response came from a demand miss
   logic [LINE_BITS-1:0] rdata_q, rdata_d;
   logic [31:0]          raddr_q, raddr_d;
   logic                 resp_q, bmem_read_q;
   logic [31:0]          bmem_addr_q;

   logic [31:0]          req_line_s, pend_line_s;
   logic [LINE_BITS-1:0] dem_line_s, pf_line_s;
   logic                 dem_done_s, pf_done_s, pend_any_s;

   assign req_line_s = line_of(dfp_addr);

   icache_line_fetcher_beat_asm #(.BEAT_BITS(BEAT_BITS)) u_dem_asm (
      .clk          (clk),
      .rst          (rst),
      .clear_i      (state_q == ST_REQ),
      .beat_valid_i ((state_q == ST_FILL) && bmem_rvalid && (bmem_raddr == cur_q)),
      .beat_i       (bmem_rdata),
      .line_o       (dem_line_s),
      .done_o       (dem_done_s)
   );

   icache_line_fetcher_beat_asm #(.BEAT_BITS(BEAT_BITS)) u_pf_asm (
      .clk          (clk),
      .rst          (rst),
      .clear_i      (state_q == ST_PF_REQ),
      .beat_valid_i ((state_q == ST_PF_FILL) && bmem_rvalid && (bmem_raddr == pf_addr_q)),
      .beat_i       (bmem_rdata),
      .line_o       (pf_line_s),
      .done_o       (pf_done_s)
   );

   // A demand that arrives in the same cycle the prefetch finishes counts as pending.
   assign pend_any_s  = pend_q || dfp_read;
   assign pend_line_s = pend_q ? cur_q : req_line_s;

   // Next-state and datapath decisions for the fetch sequencer.
   always_comb begin
      state_d    = state_q;
      cur_d      = cur_q;
      pf_addr_d  = pf_addr_q;
      pf_valid_d = pf_valid_q;
      pend_d     = pend_q;
      dmiss_d    = dmiss_q;
      rdata_d    = rdata_q;
      raddr_d    = raddr_q;
      case (state_q)
         ST_IDLE: begin
            if (dfp_read && pf_valid_q && (req_line_s == pf_addr_q)) begin
               state_d    = ST_RESP;
               rdata_d    = pf_line_s;
               raddr_d    = pf_addr_q;
               pf_valid_d = 1'b0;
               dmiss_d    = 1'b0;
            end else if (dfp_read) begin
               state_d = ST_REQ;
               cur_d   = req_line_s;
               dmiss_d = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (bmem_ready) begin
               state_d = ST_FILL;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_FILL: begin
            if (dem_done_s) begin
               state_d = ST_RESP;
               rdata_d = dem_line_s;
               raddr_d = cur_q;
            end else begin
               state_d = ST_FILL;
            end
         end
         ST_RESP: begin
            state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (PREFETCH_EN && dmiss_q) begin
               state_d    = ST_PF_REQ;
               pf_addr_d  = cur_q + LINE_BYTES;
               pf_valid_d = 1'b0;
               pend_d     = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PF_REQ: begin
            if (dfp_read && !pend_q) begin
               pend_d = 1'b1;
               cur_d  = req_line_s;
            end else begin
               pend_d = pend_q;
            end
            if (bmem_ready) begin
               state_d = ST_PF_FILL;
            end else begin
               state_d = ST_PF_REQ;
            end
         end
         ST_PF_FILL: begin
            if (pf_done_s) begin
               pf_valid_d = 1'b1;
               pend_d     = 1'b0;
               if (pend_any_s && (pend_line_s == pf_addr_q)) begin
                  state_d    = ST_RESP;
                  rdata_d    = pf_line_s;
                  raddr_d    = pf_addr_q;
                  pf_valid_d = 1'b0;
                  dmiss_d    = 1'b0;
               end else if (pend_any_s) begin
                  state_d = ST_REQ;
                  cur_d   = pend_line_s;
                  dmiss_d = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (dfp_read && !pend_q) begin
               pend_d = 1'b1;
               cur_d  = req_line_s;
            end else begin
               state_d = ST_PF_FILL;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, bookkeeping and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cur_q       <= 32'd0;
         pf_addr_q   <= 32'd0;
         pf_valid_q  <= 1'b0;
         pend_q      <= 1'b0;
         dmiss_q     <= 1'b0;
         rdata_q     <= '0;
         raddr_q     <= 32'd0;
         resp_q      <= 1'b0;
         bmem_read_q <= 1'b0;
         bmem_addr_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         pf_addr_q   <= pf_addr_d;
         pf_valid_q  <= pf_valid_d;
         pend_q      <= pend_d;
         dmiss_q     <= dmiss_d;
         rdata_q     <= rdata_d;
         raddr_q     <= raddr_d;
         resp_q      <= (state_d == ST_RESP);
         bmem_read_q <= (state_d == ST_REQ) || (state_d == ST_PF_REQ);
         if (state_d == ST_REQ) begin
            bmem_addr_q <= cur_d;
         end else if (state_d == ST_PF_REQ) begin
            bmem_addr_q <= pf_addr_d;
         end else begin
            bmem_addr_q <= 32'd0;
         end
      end
   end

   assign dfp_rdata = rdata_q;
   assign dfp_raddr = raddr_q;
   assign dfp_resp  = resp_q;
   assign bmem_addr = bmem_addr_q;
   assign bmem_read = bmem_read_q;

endmodule
